// File: rtl/pipe_stage_buf.sv
// Two-entry skid-buffered pipeline register with flush-to-bubble; optional stats via PIPE_STAGE_STATS_EN.
// Latency: 1 cycle from in_fire to out_valid; full throughput of one word per cycle.
// Backpressure: in_ready comes only from registered state, so out_ready has no combinational path to in_ready.
module pipe_stage_buf #(
    parameter int                CTRL_W      = 20,
    parameter int                DATA_W      = 128,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic              in_fire;
    logic              out_fire;

    assign in_fire   = in_valid & in_ready_q;
    assign out_fire  = out_valid_q & out_ready;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_ctrl  = main_ctrl;
    assign out_data  = main_data;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            main_ctrl   <= CTRL_BUBBLE;
            main_data   <= '0;
            skid_ctrl   <= '0;
            skid_data   <= '0;
        end else if (flush) begin
            // Data field is left alone; only the control field is forced to a bubble.
            state       <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            main_ctrl   <= CTRL_BUBBLE;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state       <= ONE;
                        out_valid_q <= 1'b1;
                        main_ctrl   <= in_ctrl;
                        main_data   <= in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_ctrl <= in_ctrl;
                        main_data <= in_data;
                    end else if (in_fire) begin
                        state      <= FULL;
                        in_ready_q <= 1'b0;
                        skid_ctrl  <= in_ctrl;
                        skid_data  <= in_data;
                    end else if (out_fire) begin
                        state       <= EMPTY;
                        out_valid_q <= 1'b0;
                        main_ctrl   <= CTRL_BUBBLE;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state      <= ONE;
                        in_ready_q <= 1'b1;
                        main_ctrl  <= skid_ctrl;
                        main_data  <= skid_data;
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to a clean empty buffer.
                    state       <= EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    main_ctrl   <= CTRL_BUBBLE;
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (out_valid_q && !out_ready && (stall_cnt != 32'hFFFF_FFFF))
                stall_cnt <= stall_cnt + 32'd1;
            if (flush && (state != EMPTY) && (flush_cnt != 32'hFFFF_FFFF))
                flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed self-checking bench for pipe_stage_buf: reset, streaming, back-pressure, flush, reset-while-full, stats.
module tb_pipe_stage_buf;

    localparam int          CW  = 20;
    localparam int          DW  = 128;
    localparam logic [19:0] BUB = 20'hABCDE;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
`ifdef PIPE_STAGE_STATS_EN
    logic [31:0]   stall_cnt;
    logic [31:0]   flush_cnt;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    pipe_stage_buf #(.CTRL_W(CW), .DATA_W(DW), .CTRL_BUBBLE(BUB)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [CW-1:0] cf(input logic [DW-1:0] d);
        return 20'h50000 ^ d[19:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic v, input logic [DW-1:0] d);
        in_valid = v;
        in_data  = d;
        in_ctrl  = cf(d);
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; out_ready = 1'b0;
        put(1'b1, 128'h55);

        // Reset held two cycles while upstream offers a word.
        tick(); tick();
        check("rst_out_valid", 128'(out_valid), 128'(1'b0));
        check("rst_in_ready",  128'(in_ready),  128'(1'b1));
        check("rst_out_ctrl",  128'(out_ctrl),  128'(BUB));
        check("rst_out_data",  out_data,        128'h0);
`ifdef PIPE_STAGE_STATS_EN
        check("rst_stall_cnt", 128'(stall_cnt), 128'h0);
        check("rst_flush_cnt", 128'(flush_cnt), 128'h0);
`endif
        reset = 1'b1;
        put(1'b0, 128'h0);
        tick();
        check("idle_out_valid", 128'(out_valid), 128'(1'b0));

        // Back-to-back stream, each word visible one cycle after it is offered.
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            put(1'b1, 128'(i));
            tick();
            check("stream_valid", 128'(out_valid), 128'(1'b1));
            check("stream_data",  out_data,        128'(i));
            check("stream_ctrl",  128'(out_ctrl),  128'(cf(128'(i))));
            check("stream_ready", 128'(in_ready),  128'(1'b1));
        end
        put(1'b0, 128'h0);
        tick();
        check("drain_valid", 128'(out_valid), 128'(1'b0));
        check("drain_ctrl",  128'(out_ctrl),  128'(BUB));
        check("drain_data",  out_data,        128'h8);

        // Back-pressure: A then B fill the buffer, C waits upstream.
        out_ready = 1'b0;
        put(1'b1, 128'hA);
        tick();
        check("bp_one_data",  out_data,       128'hA);
        check("bp_one_ready", 128'(in_ready), 128'(1'b1));
        put(1'b1, 128'hB);
        tick();
        check("bp_full_ready", 128'(in_ready), 128'(1'b0));
        check("bp_full_data",  out_data,       128'hA);
        put(1'b1, 128'hC);
        tick();
        check("bp_hold_ready", 128'(in_ready), 128'(1'b0));
        check("bp_hold_data",  out_data,       128'hA);
        check("bp_hold_ctrl",  128'(out_ctrl), 128'(cf(128'hA)));
        out_ready = 1'b1;
        tick();
        check("bp_second_data",  out_data,       128'hB);
        check("bp_second_ready", 128'(in_ready), 128'(1'b1));
        tick();
        check("bp_third_data",  out_data,        128'hC);
        check("bp_third_valid", 128'(out_valid), 128'(1'b1));
        put(1'b0, 128'h0);
        tick();
        check("bp_empty_valid", 128'(out_valid), 128'(1'b0));

        // Flush a full buffer while a new word is offered.
        out_ready = 1'b0;
        put(1'b1, 128'h11);
        tick();
        put(1'b1, 128'h22);
        tick();
        check("fl_pre_ready", 128'(in_ready), 128'(1'b0));
        flush = 1'b1;
        put(1'b1, 128'hDEAD);
        tick();
        flush = 1'b0;
        check("fl_valid", 128'(out_valid), 128'(1'b0));
        check("fl_ctrl",  128'(out_ctrl),  128'(BUB));
        check("fl_ready", 128'(in_ready),  128'(1'b1));
        check("fl_data",  out_data,        128'h11);
`ifdef PIPE_STAGE_STATS_EN
        check("fl_flush_cnt", 128'(flush_cnt), 128'h1);
`endif
        put(1'b0, 128'h0);
        out_ready = 1'b1;
        tick();
        check("fl_after_valid", 128'(out_valid), 128'(1'b0));

        // Reset while full and stalled.
        out_ready = 1'b0;
        put(1'b1, 128'h33);
        tick();
        put(1'b1, 128'h44);
        tick();
        check("rf_pre_ready", 128'(in_ready), 128'(1'b0));
        put(1'b0, 128'h0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("rf_valid", 128'(out_valid), 128'(1'b0));
        check("rf_ready", 128'(in_ready),  128'(1'b1));
        check("rf_ctrl",  128'(out_ctrl),  128'(BUB));
        check("rf_data",  out_data,        128'h0);
        out_ready = 1'b1;
        tick();
        check("rf_after_valid", 128'(out_valid), 128'(1'b0));

        // Five stall cycles on a single live word, then flush while empty.
        out_ready = 1'b0;
        put(1'b1, 128'h66);
        tick();
        put(1'b0, 128'h0);
        for (int i = 0; i < 5; i++) tick();
        check("st_data", out_data, 128'h66);
`ifdef PIPE_STAGE_STATS_EN
        check("st_stall_cnt", 128'(stall_cnt), 128'h5);
`endif
        out_ready = 1'b1;
        tick();
        check("st_drain_valid", 128'(out_valid), 128'(1'b0));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("st_flush_empty_valid", 128'(out_valid), 128'(1'b0));
`ifdef PIPE_STAGE_STATS_EN
        check("st_stall_hold", 128'(stall_cnt), 128'h5);
        check("st_flush_cnt",  128'(flush_cnt), 128'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
